axi_wr_arbiter: RTL

- Shares one AXI4 write slave port (AW/W/B channel set) among NUM_MST upstream write masters.
- Round-robin arbitration on AW, one burst in flight at a time. Each burst is sequenced ADDR -> DATA -> RESP, and the W and B channels stay locked to the granted master for the whole burst.
- Sits between the write masters (DMA engines, test drivers) and the single downstream AXI write interconnect/slave.

---
 rtl/axi_wr_arb_pkg.sv | 29 ++
 rtl/axi_wr_arbiter_if.sv | 68 ++++++
 rtl/axi_rr_arbiter.sv | 65 ++++++
 rtl/axi_wr_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/axi_wr_arb_pkg.sv
// Shared definitions for the AXI4 write-channel arbiter.
//   - AXI field widths for the fixed-size AW/B fields
//   - BRESP encodings
//   - Burst sequencing state enum (IDLE -> ADDR -> DATA -> RESP)
package axi_wr_arb_pkg;

    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int LOCK_W   = 1;
    localparam int CACHE_W  = 4;
    localparam int PROT_W   = 3;
    localparam int QOS_W    = 4;
    localparam int REGION_W = 4;
    localparam int RESP_W   = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// AXI4 write channel bundle (AW/W/B) carrying N lanes.
// Upstream side uses N = NUM_MST (per-master payload packed lane 0 in LSBs,
// per-master valid/ready vectors); downstream side uses N = 1.
// The B payload (bid/bresp/buser) is a single copy broadcast to all lanes;
// only bvalid/bready are per lane.
// Modports:
//   master - drives AW/W payload+valid and bready (a write initiator)
//   slave  - drives awready/wready and the B channel (a write target)
interface axi_wr_arbiter_if
    import axi_wr_arb_pkg::*;
#(
    parameter int N            = 1,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH     = 8,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH  = 1
);
    logic [N*ID_WIDTH-1:0]     awid;
    logic [N*ADDR_WIDTH-1:0]   awaddr;
    logic [N*LEN_W-1:0]        awlen;
    logic [N*SIZE_W-1:0]       awsize;
    logic [N*BURST_W-1:0]      awburst;
    logic [N*LOCK_W-1:0]       awlock;
    logic [N*CACHE_W-1:0]      awcache;
    logic [N*PROT_W-1:0]       awprot;
    logic [N*QOS_W-1:0]        awqos;
    logic [N*REGION_W-1:0]     awregion;
    logic [N*AWUSER_WIDTH-1:0] awuser;
    logic [N-1:0]              awvalid;
    logic [N-1:0]              awready;

    logic [N*DATA_WIDTH-1:0]   wdata;
    logic [N*STRB_WIDTH-1:0]   wstrb;
    logic [N-1:0]              wlast;
    logic [N*WUSER_WIDTH-1:0]  wuser;
    logic [N-1:0]              wvalid;
    logic [N-1:0]              wready;

    logic [ID_WIDTH-1:0]       bid;
    logic [RESP_W-1:0]         bresp;
    logic [BUSER_WIDTH-1:0]    buser;
    logic [N-1:0]              bvalid;
    logic [N-1:0]              bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin request picker.
// Searches the request vector starting at rr_ptr and wrapping, returning the
// first eligible requester as an index plus a valid flag.
// Build option: AXI_WR_ARB_QOS_EN - when defined, only requesters carrying
// the highest awqos among the active requests are eligible; ties still go
// round-robin from rr_ptr. When undefined, qos is ignored.
// Ports:
//   req         in   per-master request
//   qos         in   per-master awqos, lane 0 in LSBs
//   rr_ptr      in   search start position
//   grant_valid out  some requester was picked
//   grant_idx   out  picked master
module axi_rr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int NUM_MST     = 4,
    parameter int GRANT_WIDTH = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic [NUM_MST-1:0]       req,
    input  logic [NUM_MST*QOS_W-1:0] qos,
    input  logic [GRANT_WIDTH-1:0]   rr_ptr,
    output logic                     grant_valid,
    output logic [GRANT_WIDTH-1:0]   grant_idx
);

    logic [NUM_MST-1:0] eligible;

`ifdef AXI_WR_ARB_QOS_EN
    logic [QOS_W-1:0] max_qos;

    always_comb begin
        max_qos = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (req[i] && (qos[i*QOS_W +: QOS_W] > max_qos))
                max_qos = qos[i*QOS_W +: QOS_W];
        end
        eligible = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            eligible[i] = req[i] && (qos[i*QOS_W +: QOS_W] == max_qos);
        end
    end
`else
    logic unused_qos;
    assign unused_qos = ^qos;
    assign eligible   = req;
`endif

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            int                     pos;
            logic [GRANT_WIDTH-1:0] pos_idx;
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_MST)
                pos = pos - NUM_MST;
            pos_idx = GRANT_WIDTH'(pos);
            if (!grant_valid && eligible[pos_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// AXI4 write-channel arbiter: shares one downstream AW/W/B port among
// NUM_MST upstream write masters. One burst in flight at a time; each burst
// runs IDLE -> ADDR -> DATA -> RESP, with W and B locked to the granted
// master for the whole burst. Round-robin on AW.
// Build option: AXI_WR_ARB_QOS_EN (see axi_rr_arbiter) enables highest-awqos
// first arbitration; by default awqos is only passed through.
// Ports:
//   aclk, areset  clock, synchronous active-high reset
//   s_axi         upstream bundle, N = NUM_MST lanes (this block is target)
//   m_axi         downstream bundle, N = 1 lane (this block is initiator)
//   grant_idx     currently granted master
//   busy          a burst is in progress (state != IDLE)
//   wlast_err     one-cycle pulse when wlast did not land on beat awlen
module axi_wr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int NUM_MST      = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH     = 8,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH  = 1,
    parameter int GRANT_WIDTH  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    axi_wr_arbiter_if.slave        s_axi,
    axi_wr_arbiter_if.master       m_axi,
    output logic [GRANT_WIDTH-1:0] grant_idx,
    output logic                   busy,
    output logic                   wlast_err
);

    arb_state_e             state_q, state_d;
    logic [GRANT_WIDTH-1:0] grant_q;
    logic [GRANT_WIDTH-1:0] rr_ptr_q;
    logic [LEN_W-1:0]       beat_cnt_q;
    logic [LEN_W-1:0]       awlen_q;
    logic                   wlast_err_q;

    logic                   arb_valid;
    logic [GRANT_WIDTH-1:0] arb_idx;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   b_hs;
    logic                   wlast_sel;
    int                     g;

    function automatic logic [GRANT_WIDTH-1:0] next_ptr(input logic [GRANT_WIDTH-1:0] cur);
        if (int'(cur) >= NUM_MST - 1)
            return '0;
        return cur + 1'b1;
    endfunction

    axi_rr_arbiter #(
        .NUM_MST     (NUM_MST),
        .GRANT_WIDTH (GRANT_WIDTH)
    ) u_rr (
        .req         (s_axi.awvalid),
        .qos         (s_axi.awqos),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    assign g = int'(grant_q);

    // Payload muxes follow the registered grant; valids are gated by state.
    assign m_axi.awid     = s_axi.awid    [g*ID_WIDTH     +: ID_WIDTH];
    assign m_axi.awaddr   = s_axi.awaddr  [g*ADDR_WIDTH   +: ADDR_WIDTH];
    assign m_axi.awlen    = s_axi.awlen   [g*LEN_W        +: LEN_W];
    assign m_axi.awsize   = s_axi.awsize  [g*SIZE_W       +: SIZE_W];
    assign m_axi.awburst  = s_axi.awburst [g*BURST_W      +: BURST_W];
    assign m_axi.awlock   = s_axi.awlock  [g*LOCK_W       +: LOCK_W];
    assign m_axi.awcache  = s_axi.awcache [g*CACHE_W      +: CACHE_W];
    assign m_axi.awprot   = s_axi.awprot  [g*PROT_W       +: PROT_W];
    assign m_axi.awqos    = s_axi.awqos   [g*QOS_W        +: QOS_W];
    assign m_axi.awregion = s_axi.awregion[g*REGION_W     +: REGION_W];
    assign m_axi.awuser   = s_axi.awuser  [g*AWUSER_WIDTH +: AWUSER_WIDTH];

    assign m_axi.wdata    = s_axi.wdata   [g*DATA_WIDTH   +: DATA_WIDTH];
    assign m_axi.wstrb    = s_axi.wstrb   [g*STRB_WIDTH   +: STRB_WIDTH];
    assign m_axi.wlast    = s_axi.wlast[grant_q];
    assign m_axi.wuser    = s_axi.wuser   [g*WUSER_WIDTH  +: WUSER_WIDTH];

    // B payload goes to everyone; only the granted lane sees bvalid.
    assign s_axi.bid      = m_axi.bid;
    assign s_axi.bresp    = m_axi.bresp;
    assign s_axi.buser    = m_axi.buser[BUSER_WIDTH-1:0];

    assign wlast_sel = s_axi.wlast[grant_q];

    always_comb begin
        state_d        = state_q;
        m_axi.awvalid  = 1'b0;
        m_axi.wvalid   = 1'b0;
        m_axi.bready   = 1'b0;
        s_axi.awready  = '0;
        s_axi.wready   = '0;
        s_axi.bvalid   = '0;
        aw_hs          = 1'b0;
        w_hs           = 1'b0;
        b_hs           = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid)
                    state_d = ADDR;
            end
            ADDR: begin
                m_axi.awvalid          = s_axi.awvalid[grant_q];
                s_axi.awready[grant_q] = m_axi.awready[0];
                aw_hs                  = s_axi.awvalid[grant_q] & m_axi.awready[0];
                if (aw_hs)
                    state_d = DATA;
            end
            DATA: begin
                m_axi.wvalid          = s_axi.wvalid[grant_q];
                s_axi.wready[grant_q] = m_axi.wready[0];
                w_hs                  = s_axi.wvalid[grant_q] & m_axi.wready[0];
                if (w_hs && wlast_sel)
                    state_d = RESP;
            end
            RESP: begin
                m_axi.bready          = s_axi.bready[grant_q];
                s_axi.bvalid[grant_q] = m_axi.bvalid[0];
                b_hs                  = s_axi.bready[grant_q] & m_axi.bvalid[0];
                if (b_hs)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wlast_err_q <= 1'b0;
            if ((state_q == IDLE) && arb_valid)
                grant_q <= arb_idx;
            if (aw_hs) begin
                rr_ptr_q   <= next_ptr(grant_q);
                beat_cnt_q <= '0;
            end
            if (w_hs) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
                // Mismatch is only reported; the burst still closes on wlast.
                if (wlast_sel && (beat_cnt_q != awlen_q))
                    wlast_err_q <= 1'b1;
            end
        end
    end

    // Burst length is payload; it is only meaningful after an AW handshake.
    always_ff @(posedge aclk) begin
        if (aw_hs)
            awlen_q <= s_axi.awlen[g*LEN_W +: LEN_W];
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);
    assign wlast_err = wlast_err_q;

endmodule
